// File: rtl/matvec_ctrl.sv
// matvec_ctrl: feeds paired a/b chunks into an external vec_product unit,
// accumulates per-row dot products and streams one tagged result per row.
module matvec_ctrl #(
  parameter int BIT_WIDTH = 4,
  parameter int VEC_SIZE  = 64,
  parameter int RES_WIDTH = BIT_WIDTH*2+$clog2(VEC_SIZE),
  parameter int ACC_WIDTH = RES_WIDTH+8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic [CNT_WIDTH-1:0]          i_num_rows,
  input  logic [CNT_WIDTH-1:0]          i_num_chunks,
  output logic                          o_busy,
  output logic                          o_done,
  input  logic                          i_in_valid,
  output logic                          o_in_ready,
  input  logic [BIT_WIDTH*VEC_SIZE-1:0] i_a,
  input  logic [BIT_WIDTH*VEC_SIZE-1:0] i_b,
  output logic [BIT_WIDTH*VEC_SIZE-1:0] o_vp_a,
  output logic [BIT_WIDTH*VEC_SIZE-1:0] o_vp_b,
  input  logic [RES_WIDTH-1:0]          i_vp_product,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic [ACC_WIDTH-1:0]          o_out_data,
  output logic [CNT_WIDTH-1:0]          o_out_row,
  output logic                          o_out_last
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] num_rows_q;
  logic [CNT_WIDTH-1:0] num_chunks_q;
  logic [CNT_WIDTH-1:0] row_cnt;
  logic [CNT_WIDTH-1:0] chunk_cnt;
  logic                 s1_valid;
  logic                 s1_last;
  logic [CNT_WIDTH-1:0] s1_row;
  logic [ACC_WIDTH-1:0] acc;

  logic                 stall;
  logic                 in_fire;
  logic                 chunk_end;
  logic                 last_beat;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] acc_sum;

  // a finished row that cannot leave blocks S1 and the accumulator
  assign stall = s1_valid & s1_last
               & o_out_valid & ~i_out_ready;
  assign o_in_ready = (state == RUN) & ~stall;
  assign in_fire = i_in_valid & o_in_ready;
  assign chunk_end =
    chunk_cnt == num_chunks_q - CNT_WIDTH'(1);
  assign last_beat = chunk_end &
    (row_cnt == num_rows_q - CNT_WIDTH'(1));
  assign prod_ext = {
    {(ACC_WIDTH-RES_WIDTH){i_vp_product[RES_WIDTH-1]}},
    i_vp_product
  };
  assign acc_sum = acc + prod_ext;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      num_rows_q   <= '0;
      num_chunks_q <= '0;
      row_cnt      <= '0;
      chunk_cnt    <= '0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            num_rows_q   <= i_num_rows;
            num_chunks_q <= i_num_chunks;
            row_cnt      <= '0;
            chunk_cnt    <= '0;
            if (i_num_rows == '0 || i_num_chunks == '0) begin
              o_done <= 1'b1;
            end else begin
              state  <= RUN;
              o_busy <= 1'b1;
            end
          end
        end
        RUN: begin
          if (in_fire) begin
            if (chunk_end) begin
              chunk_cnt <= '0;
              row_cnt   <= row_cnt + CNT_WIDTH'(1);
            end else begin
              chunk_cnt <= chunk_cnt + CNT_WIDTH'(1);
            end
            if (last_beat) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (!s1_valid && (!o_out_valid || i_out_ready)) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_vp_a      <= '0;
      o_vp_b      <= '0;
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      s1_row      <= '0;
      acc         <= '0;
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_out_row   <= '0;
      o_out_last  <= 1'b0;
    end else begin
      if (!stall) begin
        s1_valid <= in_fire;
        if (in_fire) begin
          o_vp_a  <= i_a;
          o_vp_b  <= i_b;
          s1_row  <= row_cnt;
          s1_last <= chunk_end;
        end
        if (s1_valid) begin
          if (s1_last) begin
            o_out_data <= acc_sum;
            o_out_row  <= s1_row;
            o_out_last <=
              s1_row == num_rows_q - CNT_WIDTH'(1);
            acc        <= '0;
          end else begin
            acc <= acc_sum;
          end
        end
      end
      // a new row result overrides the clear from acceptance
      if (s1_valid && s1_last && !stall) begin
        o_out_valid <= 1'b1;
      end else if (i_out_ready) begin
        o_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matvec_ctrl.sv
// tb_matvec_ctrl: random jobs against a row-sum model of the matvec
// sequencer, plus directed jobs with hand-computed results.
`timescale 1ns/1ps
module tb_matvec_ctrl;

  localparam int DW = 256;
  localparam int RW = 14;
  localparam int AW = 22;
  localparam int CW = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [CW-1:0] i_num_rows = '0;
  logic [CW-1:0] i_num_chunks = '0;
  logic          o_busy;
  logic          o_done;
  logic          i_in_valid = 1'b0;
  logic          o_in_ready;
  logic [DW-1:0] i_a = '0;
  logic [DW-1:0] i_b = '0;
  logic [DW-1:0] o_vp_a;
  logic [DW-1:0] o_vp_b;
  logic [RW-1:0] i_vp_product;
  logic          o_out_valid;
  logic          i_out_ready = 1'b0;
  logic [AW-1:0] o_out_data;
  logic [CW-1:0] o_out_row;
  logic          o_out_last;

  matvec_ctrl dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_num_rows   (i_num_rows),
    .i_num_chunks (i_num_chunks),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .i_a          (i_a),
    .i_b          (i_b),
    .o_vp_a       (o_vp_a),
    .o_vp_b       (o_vp_b),
    .i_vp_product (i_vp_product),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_out_data   (o_out_data),
    .o_out_row    (o_out_row),
    .o_out_last   (o_out_last)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [AW-1:0] d;
    logic [CW-1:0] r;
    logic          l;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          cmp_e;
  int            total = 0;
  int            bad = 0;
  int            ready_mode = 0;
  bit            gap_en = 1'b0;
  bit            junk_start = 1'b0;
  bit            hold_v = 1'b0;
  logic [AW-1:0] hold_d;
  logic [CW-1:0] hold_r;

  logic [DW-1:0] ones;
  logic [DW-1:0] m8;
  logic [DW-1:0] p7;

  function automatic int dot(input logic [DW-1:0] a,
                             input logic [DW-1:0] b);
    int s = 0;
    for (int i = 0; i < 64; i++) begin
      int x = int'($signed(a[i*4 +: 4]));
      int y = int'($signed(b[i*4 +: 4]));
      s += x * y;
    end
    return s;
  endfunction

  function automatic logic [DW-1:0] rand256();
    logic [DW-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // combinational vec_product unit
  always_comb i_vp_product = RW'(dot(o_vp_a, o_vp_b));

  task automatic chk(input string n, input longint act,
                     input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", n, act, req);
    end
  endtask

  task automatic fail(input string n);
    total++;
    bad++;
    $display("FAIL %s: actual=event required=none", n);
  endtask

  always @(posedge i_clk) begin
    #1;
    case (ready_mode)
      0:       i_out_ready = 1'b1;
      1:       i_out_ready = ($urandom_range(0, 2) != 0);
      default: i_out_ready = 1'b0;
    endcase
  end

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", o_out_valid, 1);
        chk("hold_data", o_out_data, hold_d);
        chk("hold_row", o_out_row, hold_r);
      end
      if (o_out_valid && i_out_ready) begin
        if (exp_q.size() == 0) begin
          fail("spurious_output");
        end else begin
          cmp_e = exp_q.pop_front();
          chk("out_data", o_out_data, cmp_e.d);
          chk("out_row", o_out_row, cmp_e.r);
          chk("out_last", o_out_last, cmp_e.l);
        end
      end
      hold_v = o_out_valid && !i_out_ready;
      hold_d = o_out_data;
      hold_r = o_out_row;
    end
  end

  task automatic do_start(input int rows, input int chunks);
    i_start = 1'b1;
    i_num_rows = CW'(rows);
    i_num_chunks = CW'(chunks);
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_num_rows = CW'($urandom);
    i_num_chunks = CW'($urandom);
  endtask

  task automatic send_beat(input logic [DW-1:0] a,
                           input logic [DW-1:0] b);
    int n = 0;
    if (gap_en && $urandom_range(0, 3) == 0) begin
      @(posedge i_clk);
      #1;
    end
    i_a = a;
    i_b = b;
    i_in_valid = 1'b1;
    if (junk_start) begin
      i_start = 1'($urandom_range(0, 1));
      i_num_rows = CW'($urandom);
      i_num_chunks = CW'($urandom);
    end
    @(negedge i_clk);
    while (!o_in_ready && n < 500) begin
      n++;
      @(negedge i_clk);
    end
    if (n >= 500) fail("beat_accept_timeout");
    @(posedge i_clk);
    #1;
    i_in_valid = 1'b0;
    i_start = 1'b0;
  endtask

  task automatic run_job(input int rows, input int chunks,
                         input bit rnd,
                         input logic [DW-1:0] fa,
                         input logic [DW-1:0] fb,
                         input bit model, input bit lat);
    longint        sum;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    do_start(rows, chunks);
    for (int r = 0; r < rows; r++) begin
      sum = 0;
      for (int c = 0; c < chunks; c++) begin
        a = rnd ? rand256() : fa;
        b = rnd ? rand256() : fb;
        sum += dot(a, b);
        send_beat(a, b);
        if (c == chunks - 1 && model)
          exp_q.push_back('{d: AW'(sum), r: CW'(r),
                            l: (r == rows - 1)});
        if (lat && c == chunks - 1 && r == rows - 1) begin
          chk("lat_edge0_valid", o_out_valid, 0);
          @(posedge i_clk);
          #1;
          chk("lat_edge1_valid", o_out_valid, 1);
        end
      end
    end
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge i_clk);
    while (!o_done && n < 3000) begin
      n++;
      @(negedge i_clk);
    end
    if (n >= 3000) begin
      fail("done_timeout");
    end else begin
      chk("done_busy_low", o_busy, 0);
      @(negedge i_clk);
      chk("done_one_cycle", o_done, 0);
    end
    chk("queue_drained", exp_q.size(), 0);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ones = {64{4'h1}};
    m8 = {64{4'h8}};
    p7 = {64{4'h7}};

    #3;
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_in_ready", o_in_ready, 0);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_out_data", o_out_data, 0);
    chk("rst_out_row", o_out_row, 0);
    chk("rst_out_last", o_out_last, 0);
    chk("rst_vp_zero", (o_vp_a == '0 && o_vp_b == '0), 1);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    chk("model_dot_ones", dot(ones, ones), 64);
    chk("model_dot_m8", dot(m8, m8), 4096);
    chk("model_dot_p7m8", dot(p7, m8), -3584);

    ready_mode = 0;
    gap_en = 1'b0;
    exp_q.push_back('{d: AW'(64), r: 8'd0, l: 1'b1});
    run_job(1, 1, 0, ones, ones, 0, 0);
    wait_done();

    exp_q.push_back('{d: AW'(16384), r: 8'd0, l: 1'b1});
    run_job(1, 4, 0, m8, m8, 0, 1);
    wait_done();

    exp_q.push_back('{d: AW'(-7168), r: 8'd0, l: 1'b0});
    exp_q.push_back('{d: AW'(-7168), r: 8'd1, l: 1'b1});
    run_job(2, 2, 0, p7, m8, 0, 0);
    wait_done();

    ready_mode = 2;
    @(posedge i_clk);
    #1;
    for (int r = 0; r < 3; r++)
      exp_q.push_back('{d: AW'(64), r: CW'(r), l: (r == 2)});
    do_start(3, 1);
    fork
      begin
        for (int r = 0; r < 3; r++) send_beat(ones, ones);
      end
      begin
        repeat (6) @(negedge i_clk);
        chk("stall_in_ready", o_in_ready, 0);
        chk("stall_out_valid", o_out_valid, 1);
        chk("stall_out_row", o_out_row, 0);
        repeat (4) @(posedge i_clk);
        ready_mode = 0;
      end
    join
    wait_done();

    do_start(0, 3);
    chk("zero_rows_done", o_done, 1);
    chk("zero_rows_busy", o_busy, 0);
    @(posedge i_clk);
    #1;
    chk("zero_rows_done_drop", o_done, 0);
    chk("zero_rows_no_out", o_out_valid, 0);
    do_start(5, 0);
    chk("zero_chunks_done", o_done, 1);
    chk("zero_chunks_busy", o_busy, 0);
    @(posedge i_clk);
    #1;

    ready_mode = 1;
    do_start(2, 3);
    chk("mid_busy", o_busy, 1);
    send_beat(rand256(), rand256());
    send_beat(rand256(), rand256());
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_in_ready", o_in_ready, 0);
    chk("mid_rst_out_valid", o_out_valid, 0);
    chk("mid_rst_vp_zero", (o_vp_a == '0 && o_vp_b == '0), 1);
    exp_q.delete();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    ready_mode = 0;
    exp_q.push_back('{d: AW'(64), r: 8'd0, l: 1'b1});
    run_job(1, 1, 0, ones, ones, 0, 0);
    wait_done();

    ready_mode = 1;
    gap_en = 1'b1;
    junk_start = 1'b1;
    for (int j = 0; j < 25; j++) begin
      run_job($urandom_range(1, 5), $urandom_range(1, 5),
              1, '0, '0, 1, 0);
      wait_done();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
